// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment display arbiter: active-low
// character codes, the blank frame, FSM encoding and grant helpers.
package disp_pkg;

    localparam int NREQ    = 3;
    localparam int FRAME_W = 64;

    // Active-low segment codes, bit order {dp, g, f, e, d, c, b, a}
    localparam logic [7:0] CHAR_BLANK = 8'hFF;
    localparam logic [7:0] CHAR_E     = 8'h86;
    localparam logic [7:0] CHAR_R     = 8'hAF;
    localparam logic [7:0] CHAR_0     = 8'hC0;
    localparam logic [7:0] CHAR_1     = 8'hF9;
    localparam logic [7:0] CHAR_2     = 8'hA4;
    localparam logic [7:0] CHAR_3     = 8'hB0;
    localparam logic [7:0] CHAR_4     = 8'h99;
    localparam logic [7:0] CHAR_5     = 8'h92;
    localparam logic [7:0] CHAR_6     = 8'h82;
    localparam logic [7:0] CHAR_7     = 8'hF8;
    localparam logic [7:0] CHAR_8     = 8'h80;
    localparam logic [7:0] CHAR_9     = 8'h90;

    localparam logic [FRAME_W-1:0] FRAME_BLANK = {8{CHAR_BLANK}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_LINGER = 2'd2
    } disp_state_t;

    // Isolate the lowest set bit: bit 0 is the highest-priority requester.
    function automatic logic [NREQ-1:0] lowest_onehot(input logic [NREQ-1:0] v);
        return v & (~v + 3'd1);
    endfunction

    // Index of the owner encoded in a one-hot grant (0 when idle).
    function automatic logic [1:0] onehot_idx(input logic [NREQ-1:0] g);
        if (g[1])      return 2'd1;
        else if (g[2]) return 2'd2;
        else           return 2'd0;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count 0..TICK_DIV-1 and wrap; the tick marks the wrap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt_q <= '0;
        else if (cnt_q == CNT_LAST) cnt_q <= '0;
        else                        cnt_q <= cnt_q + CNT_W'(1);
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/seg_display_arbiter.sv
// Grants the shared 8-digit frame to one of three requesters, holds the last
// frame for MIN_HOLD ticks after the owner lets go, and optionally blinks it.
module seg_display_arbiter
    import disp_pkg::*;
#(
    parameter int TICK_DIV    = 100000,
    parameter int MIN_HOLD    = 500,
    parameter int BLINK_TICKS = 250
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   req,
    input  logic [191:0] req_frame,
    input  logic [2:0]   blink_en,
    output logic [2:0]   gnt,
    output logic [63:0]  frame_out,
    output logic         frame_valid,
    output logic         release_pulse
);

    localparam int HOLD_W  = (MIN_HOLD > 0)    ? $clog2(MIN_HOLD + 1)    : 1;
    localparam int BLINK_W = (BLINK_TICKS > 0) ? $clog2(BLINK_TICKS + 1) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(MIN_HOLD);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    logic               tick;
    disp_state_t        state_q, state_d;
    logic [2:0]         gnt_q, gnt_d, higher;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               phase_q;
    logic               rel_d, rel_q;
    logic [63:0]        cur_frame, last_frame_q, frame_d, frame_q;
    logic [1:0]         owner_idx;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // gnt_q - 1 masks exactly the requesters that outrank the current owner.
    assign higher    = req & (gnt_q - 3'd1);
    assign owner_idx = onehot_idx(gnt_q);

    // Select the live frame of the current owner.
    always_comb begin
        cur_frame = req_frame[63:0];
        case (owner_idx)
            2'd1:    cur_frame = req_frame[127:64];
            2'd2:    cur_frame = req_frame[191:128];
            default: cur_frame = req_frame[63:0];
        endcase
    end

    // Next-state logic: grant, preemption, linger hold and release.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        hold_d  = hold_q;
        rel_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_OWN;
                    gnt_d   = lowest_onehot(req);
                end
            end
            ST_OWN: begin
                if (|higher) begin
                    gnt_d  = lowest_onehot(higher);
                    hold_d = HOLD_LOAD;
                    rel_d  = 1'b1;
                end else if (!(|(req & gnt_q))) begin
                    state_d = ST_LINGER;
                    hold_d  = HOLD_LOAD;
                end
            end
            ST_LINGER: begin
                if (|higher) begin
                    state_d = ST_OWN;
                    gnt_d   = lowest_onehot(higher);
                    hold_d  = HOLD_LOAD;
                    rel_d   = 1'b1;
                end else if (|(req & gnt_q)) begin
                    state_d = ST_OWN;
                end else if (hold_q == '0) begin
                    rel_d   = 1'b1;
                    gnt_d   = lowest_onehot(req);
                    state_d = (|req) ? ST_OWN : ST_IDLE;
                end else if (tick) begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Output frame: live in OWN, frozen in LINGER, blanked on the off phase.
    always_comb begin
        frame_d = FRAME_BLANK;
        if (state_q == ST_OWN)         frame_d = cur_frame;
        else if (state_q == ST_LINGER) frame_d = last_frame_q;
        if ((|(blink_en & gnt_q)) && phase_q) frame_d = FRAME_BLANK;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            hold_q       <= '0;
            rel_q        <= 1'b0;
            frame_q      <= FRAME_BLANK;
            last_frame_q <= FRAME_BLANK;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            rel_q   <= rel_d;
            frame_q <= frame_d;
            if (state_q == ST_OWN) last_frame_q <= cur_frame;
        end
    end

    // Blink phase: restarts visible on every grant change, toggles every BLINK_TICKS ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (gnt_d != gnt_q) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    assign gnt           = gnt_q;
    assign frame_out     = frame_q;
    assign frame_valid   = |gnt_q;
    assign release_pulse = rel_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with a short tick and hold.
module tb_seg_display_arbiter;

    localparam logic [63:0] F0    = 64'h86AFAFC0_F9A4B099;
    localparam logic [63:0] F1    = 64'hC0F9A4B0_99928280;
    localparam logic [63:0] F2    = 64'h9080F882_9299B0A4;
    localparam logic [63:0] BLANK = 64'hFFFFFFFF_FFFFFFFF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   req;
    logic [191:0] req_frame;
    logic [2:0]   blink_en;
    logic [2:0]   gnt;
    logic [63:0]  frame_out;
    logic         frame_valid;
    logic         release_pulse;

    int n_vec = 0;
    int n_err = 0;

    seg_display_arbiter #(
        .TICK_DIV    (4),
        .MIN_HOLD    (3),
        .BLINK_TICKS (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_frame     (req_frame),
        .blink_en      (blink_en),
        .gnt           (gnt),
        .frame_out     (frame_out),
        .frame_valid   (frame_valid),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cy(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int nb;
        int nv;
        logic bad;

        req_frame = {F2, F1, F0};
        blink_en  = 3'b000;
        req       = 3'b110;
        rst_n     = 1'b0;
        cy(3);
        check("rst_gnt",   64'(gnt), 64'(3'b000));
        check("rst_frame", frame_out, BLANK);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_rel",   64'(release_pulse), 64'd0);

        // Release reset with requesters 1 and 2 waiting
        rst_n = 1'b1;
        cy(1);
        check("grant1_gnt",   64'(gnt), 64'(3'b010));
        check("grant1_valid", 64'(frame_valid), 64'd1);
        check("grant1_frame_lag", frame_out, BLANK);
        cy(1);
        check("grant1_frame", frame_out, F1);

        // Owner 1 drops: frame1 lingers for 3 ticks, then requester 2 takes over
        req = 3'b100;
        cy(1);
        check("linger_gnt", 64'(gnt), 64'(3'b010));
        k = 0;
        bad = 1'b0;
        while (release_pulse !== 1'b1 && k < 40) begin
            if (frame_out !== F1) bad = 1'b1;
            cy(1);
            k++;
        end
        check("linger_frame_held", 64'(bad), 64'd0);
        check("linger_len_in_10_13", 64'(k >= 10 && k <= 13), 64'd1);
        check("linger_rel_gnt", 64'(gnt), 64'(3'b100));
        check("linger_rel_frame", frame_out, F1);
        cy(1);
        check("rel_one_cycle", 64'(release_pulse), 64'd0);
        check("owner2_frame", frame_out, F2);

        // Requester 0 preempts owner 2 in OWN
        req = 3'b101;
        cy(1);
        check("preempt_gnt", 64'(gnt), 64'(3'b001));
        check("preempt_rel", 64'(release_pulse), 64'd1);
        cy(1);
        check("preempt_rel_drop", 64'(release_pulse), 64'd0);
        check("preempt_frame", frame_out, F0);

        // Get requester 2 into LINGER, then preempt it immediately with requester 0
        req = 3'b100;
        k = 0;
        while (gnt !== 3'b100 && k < 30) begin
            cy(1);
            k++;
        end
        check("owner2_again", 64'(gnt), 64'(3'b100));
        req = 3'b000;
        cy(2);
        check("owner2_linger", 64'(gnt), 64'(3'b100));
        req = 3'b001;
        cy(1);
        check("linger_preempt_gnt", 64'(gnt), 64'(3'b001));
        check("linger_preempt_rel", 64'(release_pulse), 64'd1);

        // Blink owner 0: starts visible, 8-clock halves
        blink_en = 3'b001;
        cy(1);
        check("blink_start_visible", frame_out, F0);
        k = 0;
        while (frame_out !== BLANK && k < 40) begin
            cy(1);
            k++;
        end
        check("blink_reaches_blank", frame_out, BLANK);
        nb = 0;
        while (frame_out === BLANK && nb < 40) begin
            cy(1);
            nb++;
        end
        check("blink_blank_len", 64'(nb), 64'd8);
        check("blink_visible_frame", frame_out, F0);
        nv = 0;
        while (frame_out !== BLANK && nv < 40) begin
            cy(1);
            nv++;
        end
        check("blink_visible_len", 64'(nv), 64'd8);

        // Asynchronous reset in the middle of LINGER
        blink_en = 3'b000;
        req = 3'b000;
        cy(3);
        check("pre_reset_linger", 64'(gnt), 64'(3'b001));
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt",   64'(gnt), 64'(3'b000));
        check("async_rst_frame", frame_out, BLANK);
        check("async_rst_valid", 64'(frame_valid), 64'd0);
        check("async_rst_rel",   64'(release_pulse), 64'd0);
        cy(2);
        rst_n = 1'b1;
        cy(3);
        check("idle_after_rst_gnt",   64'(gnt), 64'(3'b000));
        check("idle_after_rst_frame", frame_out, BLANK);
        req = 3'b010;
        cy(1);
        check("clean_grant_gnt", 64'(gnt), 64'(3'b010));
        check("clean_grant_rel", 64'(release_pulse), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
